tmds_channel_decoder: RTL and testbench

Receive-side decoder for one TMDS channel: the inverse of the 8b/10b encoding and control-token insertion done by the HDMI/DVI output path. Takes unaligned 10-bit words from a 1:10 deserializer, finds symbol alignment by hunting for control tokens, then decodes each symbol to pixel data (8 bit, DE=1) or control bits (C1:C0, DE=0). Three instances plus a deserializer form a DVI capture path, used for loopback checks of the display output.

---
 rtl/tmds_channel_decoder.sv | 147 ++++++++++++++
 tb/tb_tmds_channel_decoder.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/tmds_channel_decoder.sv
// One TMDS receive channel: hunts for control-token alignment across the ten
// bit offsets of the deserialized stream, then decodes symbols to pixel/control.
module tmds_channel_decoder #(
  parameter int LOCK_TOKENS   = 8,
  parameter int SEARCH_WINDOW = 4096
) (
  input  logic       CLK,
  input  logic       RESET_N,
  input  logic [9:0] raw_in,
  output logic       de,
  output logic [7:0] data,
  output logic [1:0] ctl,
  output logic       locked,
  output logic [3:0] offset
);

  localparam int RUN_W  = $clog2(LOCK_TOKENS) + 1;
  localparam int IDLE_W = $clog2(SEARCH_WINDOW) + 1;
  localparam logic [RUN_W-1:0]  RUN_MAX  = RUN_W'(LOCK_TOKENS);
  localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(SEARCH_WINDOW);

  typedef enum logic {SEARCH = 1'b0, LOCK = 1'b1} state_t;

  state_t             state, state_nxt;
  logic [RUN_W-1:0]   run, run_nxt, run_inc;
  logic [IDLE_W-1:0]  idle, idle_nxt, idle_inc;
  logic [3:0]         offset_nxt;
  logic [9:0]         raw_q, raw_qq, sym_q;
  logic [19:0]        window;
  logic [4:0]         sel;
  logic               is_tok;
  logic [1:0]         tok_ctl;
  logic [7:0]         q_inv, dec;

  // Offset 0 takes the newest word whole, so aligned input sees no extra latency;
  // offsets 1..9 straddle the previous and current words.
  assign window = {raw_q, raw_qq};
  assign sel    = (offset == 4'd0) ? 5'd10 : {1'b0, offset};

  // The FSM state is visible to checkers through locked.
  assign locked = (state == LOCK);

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      raw_q  <= '0;
      raw_qq <= '0;
      sym_q  <= '0;
    end else begin
      raw_q  <= raw_in;
      raw_qq <= raw_q;
      sym_q  <= window[sel +: 10];
    end
  end

  always_comb begin
    is_tok  = 1'b1;
    tok_ctl = 2'b00;
    case (sym_q)
      10'h354: tok_ctl = 2'b00;
      10'h0AB: tok_ctl = 2'b01;
      10'h154: tok_ctl = 2'b10;
      10'h2AB: tok_ctl = 2'b11;
      default: is_tok  = 1'b0;
    endcase
  end

  always_comb begin
    q_inv  = sym_q[9] ? ~sym_q[7:0] : sym_q[7:0];
    dec    = '0;
    dec[0] = q_inv[0];
    for (int i = 1; i < 8; i++) begin
      dec[i] = sym_q[8] ? (q_inv[i] ^ q_inv[i-1]) : ~(q_inv[i] ^ q_inv[i-1]);
    end
  end

  assign run_inc  = (run == RUN_MAX) ? run : run + RUN_W'(1);
  assign idle_inc = (idle == IDLE_MAX) ? idle : idle + IDLE_W'(1);

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state  <= SEARCH;
      run    <= '0;
      idle   <= '0;
      offset <= '0;
    end else begin
      state  <= state_nxt;
      run    <= run_nxt;
      idle   <= idle_nxt;
      offset <= offset_nxt;
    end
  end

  // A token always clears idle, so window expiry can only fire on a non-token.
  always_comb begin
    state_nxt  = state;
    run_nxt    = run;
    idle_nxt   = idle;
    offset_nxt = offset;
    case (state)
      SEARCH: begin
        if (is_tok) begin
          run_nxt  = run_inc;
          idle_nxt = '0;
          if (run_inc == RUN_MAX) state_nxt = LOCK;
        end else if (idle_inc == IDLE_MAX) begin
          offset_nxt = (offset == 4'd9) ? 4'd0 : offset + 4'd1;
          run_nxt    = '0;
          idle_nxt   = '0;
        end else begin
          run_nxt  = '0;
          idle_nxt = idle_inc;
        end
      end
      LOCK: begin
        if (is_tok) begin
          idle_nxt = '0;
        end else if (idle_inc == IDLE_MAX) begin
          state_nxt = SEARCH;
          run_nxt   = '0;
          idle_nxt  = '0;
        end else begin
          idle_nxt = idle_inc;
        end
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      de   <= 1'b0;
      data <= '0;
      ctl  <= 2'b00;
    end else if (state != LOCK) begin
      de   <= 1'b0;
      data <= '0;
      ctl  <= 2'b00;
    end else if (is_tok) begin
      de   <= 1'b0;
      data <= '0;
      ctl  <= tok_ctl;
    end else begin
      de   <= 1'b1;
      data <= dec;
    end
  end

endmodule

// File: tb/tb_tmds_channel_decoder.sv
// Bench for tmds_channel_decoder: bit-stream stimulus at a chosen phase, a
// behavioural reference model compared every cycle, plus directed checks.
module tb_tmds_channel_decoder;

  localparam int LOCK_TOKENS   = 8;
  localparam int SEARCH_WINDOW = 4096;

  logic       CLK = 1'b0;
  logic       RESET_N;
  logic [9:0] raw_in;
  logic       de;
  logic [7:0] data;
  logic [1:0] ctl;
  logic       locked;
  logic [3:0] offset;

  int n_checks = 0;
  int n_errors = 0;
  bit cyc_en   = 1'b0;
  bit bq[$];

  tmds_channel_decoder #(.LOCK_TOKENS(LOCK_TOKENS), .SEARCH_WINDOW(SEARCH_WINDOW)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .raw_in(raw_in), .de(de), .data(data),
    .ctl(ctl), .locked(locked), .offset(offset)
  );

  // ---------------- clock ----------------
  always #5 CLK = ~CLK;

  // ---------------- check ----------------
  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [9:0] pick(input logic [9:0] prev, input logic [9:0] cur, input int k);
    logic [19:0] w;
    w = {cur, prev};
    if (k == 0) return cur;
    return 10'(w >> k);
  endfunction

  function automatic int tok_code(input logic [9:0] s);
    if (s == 10'h354) return 0;
    if (s == 10'h0AB) return 1;
    if (s == 10'h154) return 2;
    if (s == 10'h2AB) return 3;
    return -1;
  endfunction

  function automatic logic [7:0] tmds_dec(input logic [9:0] q);
    logic [7:0] qp;
    qp = q[9] ? ~q[7:0] : q[7:0];
    return qp ^ (qp << 1) ^ (q[8] ? 8'h00 : 8'hFE);
  endfunction

  logic [9:0] m_raw_q, m_raw_qq, m_sym;
  bit         m_lock, m_de;
  logic [7:0] m_data;
  logic [1:0] m_ctl;
  int         m_run, m_idle, m_off;

  always @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      m_raw_q <= '0; m_raw_qq <= '0; m_sym <= '0;
      m_lock <= 1'b0; m_de <= 1'b0; m_data <= '0; m_ctl <= '0;
      m_run <= 0; m_idle <= 0; m_off <= 0;
    end else begin
      m_raw_q  <= raw_in;
      m_raw_qq <= m_raw_q;
      m_sym    <= pick(m_raw_qq, m_raw_q, m_off);
      if (!m_lock) begin
        m_de <= 1'b0; m_data <= '0; m_ctl <= '0;
      end else if (tok_code(m_sym) >= 0) begin
        m_de <= 1'b0; m_data <= '0; m_ctl <= 2'(tok_code(m_sym));
      end else begin
        m_de <= 1'b1; m_data <= tmds_dec(m_sym);
      end
      if (tok_code(m_sym) >= 0) begin
        m_idle <= 0;
        if (!m_lock) begin
          m_run <= m_run + 1;
          if (m_run + 1 >= LOCK_TOKENS) m_lock <= 1'b1;
        end
      end else if (m_idle + 1 >= SEARCH_WINDOW) begin
        if (!m_lock) m_off <= (m_off + 1) % 10;
        m_lock <= 1'b0;
        m_run  <= 0;
        m_idle <= 0;
      end else begin
        m_idle <= m_idle + 1;
        if (!m_lock) m_run <= 0;
      end
    end
  end

  // Whole-output comparison against the model, away from the active edge.
  always @(negedge CLK) begin
    if (cyc_en && RESET_N) begin
      check("cycle", {locked, offset, de, data, ctl},
            {m_lock, 4'(m_off), m_de, m_data, m_ctl});
    end
  end

  // ---------------- drivers ----------------
  task automatic set_phase(input int k);
    bq.delete();
    for (int i = 0; i < k; i++) bq.push_back(1'b0);
  endtask

  task automatic send(input logic [9:0] s);
    logic [9:0] w;
    for (int i = 0; i < 10; i++) bq.push_back(s[i]);
    for (int i = 0; i < 10; i++) w[i] = bq.pop_front();
    @(negedge CLK);
    raw_in = w;
  endtask

  task automatic send_n(input logic [9:0] s, input int n);
    for (int i = 0; i < n; i++) send(s);
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RESET_N = 1'b0;
    raw_in  = '0;
    repeat (3) @(negedge CLK);
    RESET_N = 1'b1;
    set_phase(0);
  endtask

  function automatic logic [9:0] rand_data();
    logic [9:0] s;
    s = 10'($urandom_range(0, 1023));
    while (tok_code(s) >= 0) s = 10'($urandom_range(0, 1023));
    return s;
  endfunction

  function automatic logic [9:0] rand_tok();
    logic [9:0] t [4];
    t[0] = 10'h354; t[1] = 10'h0AB; t[2] = 10'h154; t[3] = 10'h2AB;
    return t[$urandom_range(0, 3)];
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    RESET_N = 1'b0;
    raw_in  = '0;
    #1;
    check("reset_vals", {locked, offset, de, data, ctl}, 16'h0000);
    cyc_en = 1'b1;
    do_reset();

    // idle line: offset hunts and wraps, never locks
    for (int n = 1; n <= 41000; n++) begin
      send(10'h000);
      if (n == 4000)  check("idle_off0", {locked, de, offset}, 6'd0);
      if (n == 4200)  check("idle_off1", {locked, de, offset}, 6'd1);
      if (n == 40000) check("idle_off9", {locked, de, offset}, 6'd9);
      if (n == 41000) check("idle_wrap", {locked, de, offset}, 6'd0);
    end

    // aligned blanking
    do_reset();
    send_n(10'h354, 10);
    check("lock_early", locked, 1'b0);
    send(10'h354);
    check("lock_8th", locked, 1'b1);
    send_n(10'h354, 9);
    check("blank_ctl", {de, ctl, offset}, 7'b0_00_0000);
    send_n(10'h154, 5);
    check("ctl_10", {de, ctl}, 3'b0_10);

    // misaligned lock at offset 3, then decode
    do_reset();
    set_phase(3);
    send_n(10'h354, 3 * SEARCH_WINDOW + 60);
    check("mis_lock", {locked, offset}, 5'b1_0011);
    send_n(10'h2AB, 5);
    send_n(10'h100, 5);
    check("dec_100", {de, data, ctl}, 11'b1_00000000_11);
    send_n(10'h000, 5);
    check("dec_000", {de, data, ctl}, 11'b1_11111110_11);
    send_n(10'h1FF, 5);
    check("dec_1ff", {de, data, ctl}, 11'b1_00000001_11);
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) send(rand_tok());
      else send(rand_data());
    end

    // loss of lock
    send_n(10'h354, 4);
    for (int i = 0; i < SEARCH_WINDOW + 10; i++) send(rand_data());
    check("unlock", {locked, offset}, 5'b0_0011);
    check("unlock_out", {de, data}, 9'd0);
    send_n(10'h0AB, 12);
    check("relock", {locked, offset}, 5'b1_0011);
    for (int i = 0; i < 50; i++) send(rand_data());

    // asynchronous reset mid-line
    #2;
    RESET_N = 1'b0;
    #1;
    check("async_rst", {locked, offset, de, data, ctl}, 16'h0000);
    raw_in = '0;
    repeat (2) @(negedge CLK);
    RESET_N = 1'b1;
    set_phase(0);
    send_n(10'h2AB, 10);
    check("rst_relock_early", locked, 1'b0);
    send(10'h2AB);
    check("rst_relock", {locked, ctl}, 3'b1_00);
    send_n(10'h2AB, 3);
    check("rst_ctl", {locked, ctl}, 3'b1_11);

    cyc_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
